// File: rtl/xmint_pkg.sv
// Shared definitions for the xmint mux/arbiter slice.
//   sel_width(n) : select width for an n-input mux. xmint_mux and the
//                  arbiter both call it, so they always agree on SEL_W.
//   arb_state_e  : arbiter handshake state (IDLE, BUSY).
package xmint_pkg;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/xmint_rr_pick.sv
// Combinational rotate-find-first.
//   cand  [N]     : candidate vector
//   ptr   [SEL_W] : scan start index (values >= N are treated as 0)
//   idx   [SEL_W] : first set index in ptr, ptr+1, ..., N-1, 0, ..., ptr-1
//   found         : |cand (idx is 0 when nothing is set)
module xmint_rr_pick #(
  parameter int unsigned N     = 3,
  parameter int unsigned SEL_W = 2
) (
  input  logic [N-1:0]     cand,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  // Two copies of cand turn the circular scan into a linear one starting at ptr.
  logic [2*N-1:0] dbl;
  int unsigned    base;
  int unsigned    pos;

  assign dbl   = {cand, cand};
  assign found = |cand;

  always_comb begin
    base = 32'(ptr);
    if (base >= N) base = 0;
    idx = '0;
    pos = 0;
    // Descending scan so the lowest offset from ptr wins.
    for (int unsigned j = N; j > 0; j--) begin
      pos = base + j - 1;
      if (dbl[pos]) idx = SEL_W'((pos >= N) ? pos - N : pos);
    end
  end

endmodule

// File: rtl/xmint_rr_arb.sv
// Round-robin arbiter driving the select of xmint_mux.
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   req       : per-requester request, held until that requester is granted
//   out_ready : downstream accepts the mux output this cycle
//   sel       : registered mux select, always < N
//   out_valid : registered; mux output selected by sel is valid
//   grant     : one-hot, out_valid & out_ready & onehot(sel)
module xmint_rr_arb
  import xmint_pkg::*;
#(
  parameter  int unsigned N     = 3,
  localparam int unsigned SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  output logic [N-1:0]     grant
);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             valid_q, valid_d;

  logic [N-1:0]     sel_oh;
  logic [SEL_W-1:0] sel_inc;
  logic [N-1:0]     pick_cand;
  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;

  always_comb begin
    sel_oh = '0;
    for (int unsigned i = 0; i < N; i++) sel_oh[i] = (sel_q == SEL_W'(i));
  end

  assign sel_inc = (sel_q == SEL_W'(N - 1)) ? '0 : sel_q + SEL_W'(1);

  // One picker serves both states: from IDLE it scans req from ptr; from BUSY
  // it scans the remaining requests (winner masked) from the post-transfer pointer.
  assign pick_cand = (state_q == BUSY) ? (req & ~sel_oh) : req;
  assign pick_ptr  = (state_q == BUSY) ? sel_inc : ptr_q;

  xmint_rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .cand  (pick_cand),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          valid_d = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (out_ready) begin
          ptr_d = sel_inc;
          if (pick_found) begin
            sel_d = pick_idx;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
    end
  end

  assign sel       = sel_q;
  assign out_valid = valid_q;
  assign grant     = (valid_q && out_ready) ? sel_oh : '0;

endmodule

// File: tb/tb_xmint_rr_arb.sv
module tb_xmint_rr_arb;

  localparam int unsigned N = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = '0;
  logic       out_ready = 1'b0;
  logic [1:0] sel;
  logic       out_valid;
  logic [2:0] grant;

  int checks   = 0;
  int failures = 0;

  xmint_rr_arb #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .grant     (grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic       rdy;
    logic       v;
    logic [1:0] sel;
    logic [2:0] g;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [2:0] q, input logic rd,
                     input logic v, input logic [1:0] s, input logic [2:0] g);
    vec_t t;
    t.rst = r; t.req = q; t.rdy = rd; t.v = v; t.sel = s; t.g = g;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic       last_v;
  logic       last_rdy;
  logic [1:0] last_sel;

  initial begin
    // Each row: inputs for one cycle and outputs expected before its rising edge.
    // Single requester, one-cycle latency, winner masked in grant cycle.
    add(1, 3'b000, 0, 0, 0, 3'b000);
    add(0, 3'b010, 1, 0, 0, 3'b000);
    add(0, 3'b010, 1, 1, 1, 3'b010);
    add(0, 3'b000, 1, 0, 1, 3'b000);
    // All request from reset: 0,1,2,0,1 with no bubbles.
    add(1, 3'b000, 0, 0, 0, 3'b000);
    add(0, 3'b111, 1, 0, 0, 3'b000);
    add(0, 3'b111, 1, 1, 0, 3'b001);
    add(0, 3'b111, 1, 1, 1, 3'b010);
    add(0, 3'b111, 1, 1, 2, 3'b100);
    add(0, 3'b111, 1, 1, 0, 3'b001);
    add(0, 3'b111, 1, 1, 1, 3'b010);
    // Five stalled cycles at sel=2, then one grant and pick of 0.
    for (int i = 0; i < 5; i++) add(0, 3'b111, 0, 1, 2, 3'b000);
    add(0, 3'b111, 1, 1, 2, 3'b100);
    add(0, 3'b111, 0, 1, 0, 3'b000);
    // ptr=1 after a grant to 0; req=101 picks 2 then wraps to 0.
    add(1, 3'b000, 0, 0, 0, 3'b000);
    add(0, 3'b001, 1, 0, 0, 3'b000);
    add(0, 3'b101, 1, 1, 0, 3'b001);
    add(0, 3'b101, 1, 1, 2, 3'b100);
    add(0, 3'b001, 1, 1, 0, 3'b001);
    add(0, 3'b000, 1, 0, 0, 3'b000);
    // req[0] rises during grant of 1: next sel is 0.
    add(0, 3'b010, 1, 0, 0, 3'b000);
    add(0, 3'b011, 1, 1, 1, 3'b010);
    add(0, 3'b001, 1, 1, 0, 3'b001);
    add(0, 3'b000, 1, 0, 0, 3'b000);

    last_v = 1'b0; last_rdy = 1'b1; last_sel = '0;
    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; req = vecs[i].req; out_ready = vecs[i].rdy;
      #1;
      check($sformatf("row%0d_valid", i), 32'(out_valid), 32'(vecs[i].v));
      check($sformatf("row%0d_sel", i), 32'(sel), 32'(vecs[i].sel));
      check($sformatf("row%0d_grant", i), 32'(grant), 32'(vecs[i].g));
      check($sformatf("row%0d_onehot", i), 32'($countones(grant) <= 1), 32'd1);
      if (last_v && !last_rdy && !vecs[i].rst)
        check($sformatf("row%0d_sel_stable", i), 32'(sel), 32'(last_sel));
      last_v = out_valid; last_rdy = out_ready; last_sel = sel;
    end

    // Asynchronous reset mid-cycle with out_valid=1, sel=2.
    @(negedge clk);
    rst = 1'b1; req = '0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; req = 3'b100; out_ready = 1'b0;
    @(negedge clk);
    #1;
    check("ar_pre_valid", 32'(out_valid), 32'd1);
    check("ar_pre_sel", 32'(sel), 32'd2);
    out_ready = 1'b1;
    #1;
    check("ar_pre_grant", 32'(grant), 32'b100);
    out_ready = 1'b0;
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    check("ar_async_valid", 32'(out_valid), 32'd0);
    check("ar_async_grant", 32'(grant), 32'd0);
    check("ar_async_sel", 32'(sel), 32'd0);
    @(negedge clk);
    rst = 1'b0; req = 3'b100; out_ready = 1'b1;
    #1;
    check("ar_rel_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    check("ar_post_valid", 32'(out_valid), 32'd1);
    check("ar_post_sel", 32'(sel), 32'd2);
    check("ar_post_grant", 32'(grant), 32'b100);
    req = 3'b000;
    @(negedge clk);
    #1;
    check("ar_idle_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
